// File: rtl/multi_channel_bcd_timer_pkg.sv
// timer_pkg: shared state codes, MM:SS digit type and BCD limits for the multi-channel timer
package timer_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSED = 2'd2, ST_DONE = 2'd3} state_e;
   typedef enum logic [2:0] {CMD_NONE, CMD_CLEAR, CMD_STOP, CMD_START, CMD_INC_MIN, CMD_INC_SEC} cmd_e;
   typedef struct packed {
      logic [3:0] m_dec;
      logic [3:0] m_unit;
      logic [3:0] s_dec;
      logic [3:0] s_unit;
   } mmss_t;
   localparam int SU_OFF = 0;
   localparam int SD_OFF = 4;
   localparam int MU_OFF = 8;
   localparam int MD_OFF = 12;
   localparam logic [3:0] MAX_SEC_TENS = 4'd5;
   localparam logic [6:0] MAX_MIN = 7'd99;
   localparam mmss_t MMSS_TOP = '{4'(MAX_MIN / 7'd10), 4'(MAX_MIN % 7'd10), MAX_SEC_TENS, 4'd9};
endpackage

// File: rtl/multi_channel_bcd_timer_if.sv
// multi_channel_bcd_timer_if: command bus from the button/state-machine layer to the timer
interface multi_channel_bcd_timer_if #(parameter int CH_W = 2);
   logic            cmd_valid;
   logic [CH_W-1:0] cmd_ch;
   logic            cmd_start;
   logic            cmd_stop;
   logic            cmd_clear;
   logic            cmd_inc_sec;
   logic            cmd_inc_min;
   logic            cmd_dir;
   modport master (output cmd_valid, cmd_ch, cmd_start, cmd_stop, cmd_clear, cmd_inc_sec, cmd_inc_min, cmd_dir);
   modport slave  (input  cmd_valid, cmd_ch, cmd_start, cmd_stop, cmd_clear, cmd_inc_sec, cmd_inc_min, cmd_dir);
endinterface

// File: rtl/multi_channel_bcd_timer_counter.sv
// bcd_mmss_counter: one MM:SS channel with run state, BCD up/down/preset stepping.
// TIMER_AUTO_RELOAD_EN adds a preset register reloaded when a down count hits 00:00.
module bcd_mmss_counter
   import timer_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   tick_i,
   input  cmd_e   cmd_i,
   input  logic   dir_i,
   output mmss_t  digits_o,
   output state_e state_o,
   output logic   finish_o
);
   state_e state_q, state_d;
   mmss_t  dig_q, dig_d, nxt;
   logic   dir_q, dir_d, fin_q, fin_d, editable;

   function automatic mmss_t bcd_up(mmss_t d);
      logic su_c, sd_c, mu_c;
      su_c = d.s_unit == 4'd9;
      sd_c = su_c && d.s_dec == MAX_SEC_TENS;
      mu_c = sd_c && d.m_unit == 4'd9;
      bcd_up.s_unit = su_c ? 4'd0 : d.s_unit + 4'd1;
      bcd_up.s_dec  = su_c ? (sd_c ? 4'd0 : d.s_dec + 4'd1) : d.s_dec;
      bcd_up.m_unit = sd_c ? (mu_c ? 4'd0 : d.m_unit + 4'd1) : d.m_unit;
      bcd_up.m_dec  = mu_c ? (d.m_dec == 4'd9 ? 4'd0 : d.m_dec + 4'd1) : d.m_dec;
   endfunction

   function automatic mmss_t bcd_down(mmss_t d);
      logic su_b, sd_b, mu_b;
      su_b = d.s_unit == 4'd0;
      sd_b = su_b && d.s_dec == 4'd0;
      mu_b = sd_b && d.m_unit == 4'd0;
      bcd_down.s_unit = su_b ? 4'd9 : d.s_unit - 4'd1;
      bcd_down.s_dec  = su_b ? (sd_b ? MAX_SEC_TENS : d.s_dec - 4'd1) : d.s_dec;
      bcd_down.m_unit = sd_b ? (mu_b ? 4'd9 : d.m_unit - 4'd1) : d.m_unit;
      bcd_down.m_dec  = mu_b ? d.m_dec - 4'd1 : d.m_dec;
   endfunction

   // preset stepping wraps within its own field, never carrying
   function automatic mmss_t step_sec(mmss_t d);
      step_sec = d;
      step_sec.s_unit = d.s_unit == 4'd9 ? 4'd0 : d.s_unit + 4'd1;
      step_sec.s_dec  = d.s_unit == 4'd9 ? (d.s_dec == MAX_SEC_TENS ? 4'd0 : d.s_dec + 4'd1) : d.s_dec;
   endfunction

   function automatic mmss_t step_min(mmss_t d);
      step_min = d;
      step_min.m_unit = d.m_unit == 4'd9 ? 4'd0 : d.m_unit + 4'd1;
      step_min.m_dec  = d.m_unit == 4'd9 ? (d.m_dec == MMSS_TOP.m_dec ? 4'd0 : d.m_dec + 4'd1) : d.m_dec;
   endfunction

`ifdef TIMER_AUTO_RELOAD_EN
   mmss_t pre_q, pre_d;
   always_ff @(posedge clk)
      pre_q <= reset ? '0 : pre_d;
`endif

   always_comb begin
      state_d  = state_q;
      dig_d    = dig_q;
      dir_d    = dir_q;
      fin_d    = fin_q && state_q == ST_DONE;
      editable = state_q == ST_IDLE || state_q == ST_PAUSED;
      nxt      = dir_q ? bcd_up(dig_q) : bcd_down(dig_q);
`ifdef TIMER_AUTO_RELOAD_EN
      pre_d    = pre_q;
`endif
      if (cmd_i == CMD_CLEAR) begin
         state_d = ST_IDLE;
         dig_d   = '0;
         fin_d   = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
         pre_d   = '0;
`endif
      end else if (cmd_i == CMD_STOP) begin
         state_d = state_q == ST_RUN ? ST_PAUSED : state_q;
      end else if (cmd_i == CMD_START) begin
         if (editable && (dir_i || dig_q != '0)) begin
            state_d = ST_RUN;
            dir_d   = dir_i;
`ifdef TIMER_AUTO_RELOAD_EN
            pre_d   = dig_q;
`endif
         end
      end else if (cmd_i == CMD_INC_MIN) begin
         dig_d = editable ? step_min(dig_q) : dig_q;
      end else if (cmd_i == CMD_INC_SEC) begin
         dig_d = editable ? step_sec(dig_q) : dig_q;
      end else if (tick_i && state_q == ST_RUN) begin
         if (dir_q) begin
            dig_d = dig_q == MMSS_TOP ? dig_q : nxt;
            if (dig_d == MMSS_TOP) begin
               state_d = ST_DONE;
               fin_d   = 1'b1;
            end
         end else if (nxt == '0) begin
            fin_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
            dig_d = pre_q;
`else
            dig_d   = '0;
            state_d = ST_DONE;
`endif
         end else begin
            dig_d = nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         dig_q   <= '0;
         dir_q   <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         dir_q   <= dir_d;
         fin_q   <= fin_d;
      end
   end

   assign digits_o = dig_q;
   assign state_o  = state_q;
   assign finish_o = fin_q;
endmodule

// File: rtl/multi_channel_bcd_timer.sv
// multi_channel_bcd_timer: N_CH BCD MM:SS timers sharing one 1 s prescaler.
// Optional TIMER_AUTO_RELOAD_EN makes down-counting channels reload their start value.
module multi_channel_bcd_timer
   import timer_pkg::*;
#(
   parameter int TICK_DIV = 50000000,
   parameter int N_CH     = 4,
   parameter int CH_W     = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   multi_channel_bcd_timer_if.slave   cmd,
   output logic [16*N_CH-1:0]         digits,
   output logic [2*N_CH-1:0]          ch_state,
   output logic [N_CH-1:0]            finish,
   output logic                       tick
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0]   cnt_q;
   logic [CH_W-1:0] ch_w;
   cmd_e            cmd_w;

   assign tick = cnt_q == PW'(TICK_DIV - 1);

   always_ff @(posedge clk)
      cnt_q <= (reset || tick) ? '0 : cnt_q + 1'b1;

   assign ch_w = cmd.cmd_ch;

   always_comb
      cmd_w = (!cmd.cmd_valid || 32'(ch_w) >= N_CH) ? CMD_NONE :
              cmd.cmd_clear   ? CMD_CLEAR   :
              cmd.cmd_stop    ? CMD_STOP    :
              cmd.cmd_start   ? CMD_START   :
              cmd.cmd_inc_min ? CMD_INC_MIN :
              cmd.cmd_inc_sec ? CMD_INC_SEC : CMD_NONE;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      bcd_mmss_counter u_cnt (
         .clk      (clk),
         .reset    (reset),
         .tick_i   (tick),
         .cmd_i    (32'(ch_w) == c ? cmd_w : CMD_NONE),
         .dir_i    (cmd.cmd_dir),
         .digits_o (digits[16*c +: 16]),
         .state_o  (ch_state[2*c +: 2]),
         .finish_o (finish[c])
      );
   end
endmodule

// File: tb/tb_multi_channel_bcd_timer.sv
// tb_multi_channel_bcd_timer: directed + random commands checked against a seconds-based reference model
module tb_multi_channel_bcd_timer;
   localparam int N = 4;
   localparam logic [5:0] CLR = 6'b100000, STP = 6'b010000, STA = 6'b001000;
   localparam logic [5:0] IMN = 6'b000100, ISC = 6'b000010, UP = 6'b000001;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [16*N-1:0] digits;
   logic [2*N-1:0]  ch_state;
   logic [N-1:0]    finish;
   logic            tick;
   int n_chk = 0, n_fail = 0;
   int mm[N], ss[N], st[N], pm[N], ps[N], pc;
   bit dr[N], fn[N];

   multi_channel_bcd_timer_if #(.CH_W(3)) bus ();

   multi_channel_bcd_timer #(.TICK_DIV(4), .N_CH(N), .CH_W(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd      (bus.slave),
      .digits   (digits),
      .ch_state (ch_state),
      .finish   (finish),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_digits();
      logic [63:0] r = '0;
      for (int i = 0; i < N; i++)
         r[16*i +: 16] = {4'(mm[i] / 10), 4'(mm[i] % 10), 4'(ss[i] / 10), 4'(ss[i] % 10)};
      return r;
   endfunction

   function automatic logic [63:0] exp_state();
      logic [63:0] r = '0;
      for (int i = 0; i < N; i++) r[2*i +: 2] = 2'(st[i]);
      return r;
   endfunction

   function automatic logic [63:0] exp_fin();
      logic [63:0] r = '0;
      for (int i = 0; i < N; i++) r[i] = fn[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mm[i] = 0; ss[i] = 0; st[i] = 0; pm[i] = 0; ps[i] = 0; dr[i] = 0; fn[i] = 0;
      end
      pc = 0;
   endtask

   // states: 0 idle, 1 run, 2 paused, 3 done; time kept as whole seconds
   task automatic model_step(bit v, int ch, logic [5:0] op, bit tk);
      for (int i = 0; i < N; i++) begin
         int t = mm[i] * 60 + ss[i];
         bit ed = st[i] == 0 || st[i] == 2;
         if (st[i] != 3) fn[i] = 0;
         if (v && ch == i && op[5:1] != 0) begin
            if (op[5]) begin
               t = 0; st[i] = 0; fn[i] = 0; pm[i] = 0; ps[i] = 0;
            end else if (op[4]) begin
               if (st[i] == 1) st[i] = 2;
            end else if (op[3]) begin
               if (ed && (op[0] || t > 0)) begin
                  st[i] = 1; dr[i] = op[0]; pm[i] = mm[i]; ps[i] = ss[i];
               end
            end else if (op[2]) begin
               if (ed) t = ((mm[i] + 1) % 100) * 60 + ss[i];
            end else if (ed) begin
               t = mm[i] * 60 + (ss[i] + 1) % 60;
            end
         end else if (tk && st[i] == 1) begin
            if (dr[i]) begin
               if (t < 5999) t++;
               if (t == 5999) begin st[i] = 3; fn[i] = 1; end
            end else begin
               t--;
               if (t == 0) begin
                  fn[i] = 1;
`ifdef TIMER_AUTO_RELOAD_EN
                  t = pm[i] * 60 + ps[i];
`else
                  st[i] = 3;
`endif
               end
            end
         end
         mm[i] = t / 60;
         ss[i] = t % 60;
      end
   endtask

   task automatic cyc(bit v, int ch, logic [5:0] op);
      bit tk;
      bus.cmd_valid = v;
      bus.cmd_ch = 3'(ch);
      {bus.cmd_clear, bus.cmd_stop, bus.cmd_start, bus.cmd_inc_min, bus.cmd_inc_sec, bus.cmd_dir} = op;
      #4 check("tick", tick, pc == 3);
      tk = pc == 3;
      @(posedge clk);
      model_step(v, ch, op, tk);
      pc = (pc + 1) % 4;
      #1;
      check("digits", digits, exp_digits());
      check("ch_state", ch_state, exp_state());
      check("finish", finish, exp_fin());
      bus.cmd_valid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) cyc(0, 0, 6'b0);
   endtask

   task automatic rep(int ch, logic [5:0] op, int n);
      repeat (n) cyc(1, ch, op);
   endtask

   initial begin
      model_reset();
      bus.cmd_valid = 1'b0;
      bus.cmd_ch = '0;
      {bus.cmd_clear, bus.cmd_stop, bus.cmd_start, bus.cmd_inc_min, bus.cmd_inc_sec, bus.cmd_dir} = 6'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_digits", digits, 64'h0);
      check("rst_state", ch_state, 8'h0);
      check("rst_finish", finish, 4'h0);
      check("rst_tick", tick, 1'b0);
      idle(8);

      rep(2, IMN, 1);
      rep(2, ISC, 2);
      check("ch2_preset", digits[47:32], 16'h0102);
      cyc(1, 2, STA);
      idle(62 * 4 + 4);
      check("ch2_end_digits", digits[47:32], 16'h0000);
      check("ch2_done", ch_state[5:4], 2'd3);
      check("ch2_finish", finish[2], 1'b1);
      check("ch2_others", {digits[63:48], digits[31:0]}, 48'h0);

      rep(0, IMN, 99);
      rep(0, ISC, 58);
      check("ch0_preset", digits[15:0], 16'h9958);
      cyc(1, 0, STA | UP);
      idle(12);
      check("ch0_top", digits[15:0], 16'h9959);
      check("ch0_done", ch_state[1:0], 2'd3);
      check("ch0_finish", finish[0], 1'b1);
      idle(8);
      check("ch0_hold", digits[15:0], 16'h9959);

      rep(3, ISC, 60);
      check("sec_wrap", digits[63:48], 16'h0000);
      rep(3, IMN, 100);
      check("min_wrap", digits[63:48], 16'h0000);
      rep(3, ISC, 7);
      cyc(1, 3, STA | UP);
      rep(3, ISC, 3);
      rep(3, IMN, 2);
      check("inc_in_run", digits[63:48], 16'h0007);
      idle(9);
      cyc(1, 3, STP);
      check("stop_paused", ch_state[7:6], 2'd2);
      cyc(1, 3, STA);
      idle(6);

      rep(1, ISC, 5);
      cyc(1, 1, STA | UP);
      idle(9);
      cyc(1, 1, CLR | STA);
      check("prio_state", ch_state[3:2], 2'd0);
      check("prio_digits", digits[31:16], 16'h0000);
      cyc(1, 5, IMN);
      cyc(1, 5, STA | UP);
      check("bad_ch", digits[31:16], 16'h0000);
      cyc(1, 1, STA);
      check("start_zero_down", ch_state[3:2], 2'd0);

`ifdef TIMER_AUTO_RELOAD_EN
      cyc(1, 3, CLR);
      rep(3, ISC, 3);
      cyc(1, 3, STA);
      idle(20);
      check("reload_run", ch_state[7:6], 2'd1);
`endif

      for (int i = 0; i < N; i++) cyc(1, i, CLR);
      repeat (800) begin
         if ($urandom_range(0, 2) == 0)
            cyc(1, $urandom_range(0, 7),
                {$urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 0, 1'($urandom)});
         else
            cyc(0, 0, 6'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/multi_channel_bcd_timer.md
Name: multi_channel_bcd_timer

Overview:
Parametrised successor to the single MM:SS countdown/count-up timer core. Holds N_CH independent BCD MM:SS timers that share one free-running 1 s prescaler. Each channel has its own run state, direction and finish flag. Sits between the debounced button/state-machine layer and the VGA painter, which reads the packed digits and states.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick; the bench uses 4.
N_CH, 4, number of timer channels, 1..8.
CH_W, 2, width of channel select; must satisfy 2**CH_W >= N_CH.

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high
cmd_valid  in  1  command strobe, one cycle per command
cmd_ch  in  CH_W  target channel; values >= N_CH are ignored
cmd_start  in  1  start/resume the channel
cmd_stop  in  1  pause the channel
cmd_clear  in  1  zero the channel and return it to IDLE
cmd_inc_sec  in  1  preset: seconds +1
cmd_inc_min  in  1  preset: minutes +1
cmd_dir  in  1  direction sampled on start: 1 = count up, 0 = count down
digits  out  16*N_CH  per channel {mDec,mUnit,sDec,sUnit}; channel 0 in the LSBs
ch_state  out  2*N_CH  per-channel state code
finish  out  N_CH  per-channel finish flag
tick  out  1  one-cycle 1 s prescaler pulse, for debug

Behaviour:
- Reset: all digits 0, all states IDLE, finish 0, prescaler 0, tick 0, all directions = down.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly the one cycle in which the count equals TICK_DIV-1.
  - Free-running; it is never restarted by start/stop.
- Channel states (codes): IDLE=0, RUN=1, PAUSED=2, DONE=3.
- Commands act only when cmd_valid=1 and cmd_ch < N_CH, and take effect at the next clk edge.
- Priority when several cmd bits are set: clear > stop > start > inc_min > inc_sec. Only the highest-priority bit is executed.
- Transitions:
  - clear, from any state: digits=0, IDLE, finish=0.
  - start from IDLE or PAUSED: latch cmd_dir, go to RUN. Exception: if the latched direction is down and the digits are 00:00, stay in the current state.
  - start in RUN or DONE: ignored.
  - stop in RUN: go to PAUSED. stop in any other state: ignored.
  - inc_sec / inc_min: honoured only in IDLE or PAUSED.
    - sUnit/sDec step 00..59 and wrap 59->00 with no carry into minutes.
    - Minutes step 00..99 and wrap 99->00.
- Counting: applied to every channel in RUN on a cycle where tick=1; the digits update on that same edge.
  - Up: full BCD carry, :59 -> next minute. On reaching 99:59 the channel enters DONE with finish=1 on that same edge; the digits hold at 99:59.
  - Down: full BCD borrow, :00 -> previous minute :59. On reaching 00:00 the channel enters DONE with finish=1 on that same edge.
- finish: a level that stays high while in DONE; cleared only by clear or reset.
- Tick coincident with a command to the same channel: the command wins and the tick is skipped for that channel only. Other channels still count.
- Digits are always valid BCD: each nibble <= 9, sDec <= 5.
- Reset mid-run has the same result as the reset values above.

Optional Feature:
Macro TIMER_AUTO_RELOAD_EN.
- Defined:
  - On start, each channel latches its current digits into a per-channel preset register.
  - When a down-counting channel reaches 00:00, it reloads the preset on that same edge and stays in RUN.
  - finish pulses high for exactly one cycle.
  - Up-counting channels behave as without the macro.
  - clear also zeroes the preset.
- Undefined: no preset registers are built; behaviour is exactly as in Behaviour.

Decomposition:
- Shared package timer_pkg holds:
  - state codes ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE;
  - the 16-bit MM:SS digit typedef and its field offsets;
  - the constants MAX_SEC_TENS=5 and MAX_MIN=99.
- One sub-module, bcd_mmss_counter, is generated per channel. It contains the state register, BCD up/down/preset-increment logic and the optional reload.
- The top level holds the prescaler, command decode and output packing.

Test Plan:
- TICK_DIV=4, N_CH=4, reset -> all digits 0000, ch_state 0, finish 0, tick every 4th cycle.
- Channel 2 countdown:
  - Stimulus: inc_min x1, inc_sec x2 on ch 2, then start with dir=0.
  - Required: digits[47:32] go 0102 -> 0101 -> 0100 -> 0059 ... -> 0000. State DONE and finish[2]=1 on the 62nd tick. Channels 0, 1, 3 stay 0000.
- Channel 0 count-up:
  - Stimulus: preset 99:58, start with dir=1.
  - Required: 9959 then DONE at 9959, finish[0]=1. Further ticks leave the digits unchanged.
- Wrap on increment:
  - inc_sec x60 from 00:00 -> 00:00 with minutes unchanged.
  - inc_min x100 -> 00:00.
  - inc while in RUN -> digits unchanged.
- Priority and ignored commands:
  - cmd_clear+cmd_start together on ch 1 in RUN -> IDLE, 0000.
  - cmd_ch=5 with N_CH=4 -> no change.
  - start on 00:00 with dir=0 -> stays IDLE.
- With TIMER_AUTO_RELOAD_EN:
  - Preset 00:03, start down -> 0002, 0001, 0000->0003 reload, one-cycle finish pulse, state remains RUN.
